// File: rtl/vga_timing_if.sv
// Signal bundle between the VGA timing generator, the pixel colour source and the DAC pins.
// Optional frame counter member is present only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if;
   logic [10:0] draw_x;
   logic [9:0]  draw_y;
   logic [3:0]  r_in;
   logic [3:0]  g_in;
   logic [3:0]  b_in;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        vga_hs;
   logic        vga_vs;
   logic        video_on;
   logic        frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   modport master (
      input  r_in, g_in, b_in,
      output draw_x, draw_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, video_on, frame_start
`ifdef VGA_FRAME_CNT_EN
      , output frame_cnt
`endif
   );

   modport slave (
      output r_in, g_in, b_in,
      input  draw_x, draw_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, video_on, frame_start
`ifdef VGA_FRAME_CNT_EN
      , input frame_cnt
`endif
   );
endinterface

// File: rtl/vga_timing.sv
// 1440x900 VGA timing generator (1904x932 total) with one-cycle registered, blank-gated outputs.
// Define VGA_FRAME_CNT_EN to add a 16-bit wrapping frame counter on the interface.
module vga_timing (
   input  logic          clk,
   input  logic          rst_n,
   vga_timing_if.master  bus
);

   localparam logic [10:0] H_VISIBLE    = 11'd1440;
   localparam logic [10:0] H_SYNC_START = 11'd1520;
   localparam logic [10:0] H_SYNC_END   = 11'd1671;
   localparam logic [10:0] H_MAX        = 11'd1903;
   localparam logic [9:0]  V_VISIBLE    = 10'd900;
   localparam logic [9:0]  V_SYNC_START = 10'd901;
   localparam logic [9:0]  V_SYNC_END   = 10'd903;
   localparam logic [9:0]  V_MAX        = 10'd931;

   logic [10:0] h_cnt;
   logic [10:0] h_next;
   logic [9:0]  v_cnt;
   logic [9:0]  v_next;
   logic        h_wrap;
   logic        visible;
   logic        hs_next;
   logic        vs_next;
   logic        start_next;

   // Wrap tests use >= so a counter can never run past its maximum.
   always_comb begin
      h_wrap     = (h_cnt >= H_MAX);
      h_next     = h_wrap ? 11'd0 : h_cnt + 11'd1;
      v_next     = v_cnt;
      if (h_wrap) begin
         v_next = (v_cnt >= V_MAX) ? 10'd0 : v_cnt + 10'd1;
      end
      visible    = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
      hs_next    = !((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END));
      vs_next    = (v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END);
      start_next = (h_cnt == 11'd0) && (v_cnt == 10'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= 11'd0;
         v_cnt <= 10'd0;
      end else begin
         h_cnt <= h_next;
         v_cnt <= v_next;
      end
   end

   assign bus.draw_x = h_cnt;
   assign bus.draw_y = v_cnt;

   // Every registered output is decoded from the counter pair of the cycle before.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.vga_r       <= 4'd0;
         bus.vga_g       <= 4'd0;
         bus.vga_b       <= 4'd0;
         bus.vga_hs      <= 1'b1;
         bus.vga_vs      <= 1'b0;
         bus.video_on    <= 1'b0;
         bus.frame_start <= 1'b0;
      end else begin
         bus.vga_r       <= visible ? bus.r_in : 4'd0;
         bus.vga_g       <= visible ? bus.g_in : 4'd0;
         bus.vga_b       <= visible ? bus.b_in : 4'd0;
         bus.vga_hs      <= hs_next;
         bus.vga_vs      <= vs_next;
         bus.video_on    <= visible;
         bus.frame_start <= start_next;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.frame_cnt <= 16'd0;
      end else if (start_next) begin
         bus.frame_cnt <= bus.frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: randomized colours and counter jumps against a raster-index model.
// Honours VGA_FRAME_CNT_EN the same way as the design.
module tb_vga_timing;

   localparam int H_TOTAL = 1904;
   localparam int V_TOTAL = 932;
`ifdef VGA_FRAME_CNT_EN
   localparam int VW = 53;
`else
   localparam int VW = 37;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   vga_timing_if bus ();

   vga_timing dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int mh;
   int mv;
   logic [3:0]  er;
   logic [3:0]  eg;
   logic [3:0]  eb;
   logic        ehs;
   logic        evs;
   logic        evon;
   logic        efs;
   logic [15:0] efc;

   logic [10:0] dep_h;
   logic [9:0]  dep_v;
   logic [15:0] dep_fc;

   function void model_reset();
      mh   = 0;
      mv   = 0;
      er   = 4'd0;
      eg   = 4'd0;
      eb   = 4'd0;
      ehs  = 1'b1;
      evs  = 1'b0;
      evon = 1'b0;
      efs  = 1'b0;
      efc  = 16'd0;
   endfunction

   // Outputs follow from the raster position; the next position is the linear index plus one.
   function void model_edge(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      bit vis;
      int pos;
      vis  = (mh < 1440) && (mv < 900);
      er   = vis ? r : 4'd0;
      eg   = vis ? g : 4'd0;
      eb   = vis ? b : 4'd0;
      ehs  = !(mh >= 1520 && mh < 1520 + 152);
      evs  = (mv >= 901) && (mv < 901 + 3);
      evon = vis;
      efs  = (mh == 0) && (mv == 0);
      if (efs) efc = efc + 16'd1;
      pos  = (mv * H_TOTAL + mh + 1) % (H_TOTAL * V_TOTAL);
      mh   = pos % H_TOTAL;
      mv   = pos / H_TOTAL;
   endfunction

   task automatic checkOutput(input string name);
      logic [VW-1:0] act;
      logic [VW-1:0] exp;
      act = {bus.draw_x, bus.draw_y, bus.vga_r, bus.vga_g, bus.vga_b,
             bus.vga_hs, bus.vga_vs, bus.video_on, bus.frame_start
`ifdef VGA_FRAME_CNT_EN
             , bus.frame_cnt
`endif
             };
      exp = {11'(mh), 10'(mv), er, eg, eb, ehs, evs, evon, efs
`ifdef VGA_FRAME_CNT_EN
             , efc
`endif
             };
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic checkLit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Called at a falling edge: drive colour, advance the model, let one rising edge pass, compare.
   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      bus.r_in = r;
      bus.g_in = g;
      bus.b_in = b;
      if (rst_n) model_edge(r, g, b);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      checkOutput("cycle");
   endtask

   task automatic stepRandom();
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
   endtask

   // Jump the raster counters to (h,v) between edges so distant regions are reached quickly.
   task automatic jumpTo(input int h, input int v);
      dep_h = 11'(h);
      dep_v = 10'(v);
      force dut.h_cnt = dep_h;
      force dut.v_cnt = dep_v;
      #1;
      release dut.h_cnt;
      release dut.v_cnt;
      mh = h;
      mv = v;
      checkOutput("jump");
   endtask

   // Asynchronous reset asserted between edges, held across one rising edge, released at a falling edge.
   task automatic pulseReset();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      checkOutput("async_reset");
      checkLit("async_reset_hs", int'(bus.vga_hs), 1);
      checkLit("async_reset_vs", int'(bus.vga_vs), 0);
      @(negedge clk);
      checkOutput("reset_held");
      rst_n = 1'b1;
   endtask

   initial begin
      int fall1;
      int fall2;
      int low_cnt;
      int von_cnt;
      int fff_cnt;
      int vs_rise;
      int vs_fall;
      logic prev_hs;
      logic prev_vs;

      $display("[TB] start");
      model_reset();
      bus.r_in = 4'd0;
      bus.g_in = 4'd0;
      bus.b_in = 4'd0;
      @(negedge clk);
      checkOutput("reset");
      @(negedge clk);
      checkOutput("reset");
      rst_n = 1'b1;

      // Two lines of full-white after release: hsync placement and visible run length.
      fall1 = -1;
      fall2 = -1;
      low_cnt = 0;
      von_cnt = 0;
      fff_cnt = 0;
      prev_hs = 1'b1;
      for (int n = 1; n <= 2 * H_TOTAL + 40; n++) begin
         applyStimulus(4'hF, 4'hF, 4'hF);
         if (n == 1) begin
            checkLit("first_frame_start", int'(bus.frame_start), 1);
            checkLit("first_draw_x", int'(bus.draw_x), 1);
         end
         if (prev_hs && !bus.vga_hs) begin
            if (fall1 < 0) fall1 = n;
            else if (fall2 < 0) fall2 = n;
         end
         prev_hs = bus.vga_hs;
         if (n <= H_TOTAL) begin
            if (!bus.vga_hs) low_cnt++;
            if (bus.video_on) von_cnt++;
            if ({bus.vga_r, bus.vga_g, bus.vga_b} == 12'hFFF) fff_cnt++;
         end
      end
      checkLit("hs_first_fall", fall1, 1521);
      checkLit("hs_period", fall2 - fall1, 1904);
      checkLit("hs_low_width", low_cnt, 152);
      checkLit("video_on_per_line", von_cnt, 1440);
      checkLit("white_per_line", fff_cnt, 1440);

      // Vertical sync window around lines 901..903.
      jumpTo(1900, 900);
      vs_rise = -1;
      vs_fall = -1;
      prev_vs = bus.vga_vs;
      for (int n = 1; n <= 4 * H_TOTAL; n++) begin
         stepRandom();
         if (!prev_vs && bus.vga_vs && vs_rise < 0) vs_rise = n;
         if (prev_vs && !bus.vga_vs && vs_fall < 0) vs_fall = n;
         prev_vs = bus.vga_vs;
      end
      checkLit("vs_rise", vs_rise, 5);
      checkLit("vs_high_width", vs_fall - vs_rise, 5712);

      // Counter boundaries: end of last visible line, and end of frame.
      jumpTo(1902, 899);
      stepRandom();
      stepRandom();
      checkLit("wrap_899_x", int'(bus.draw_x), 0);
      checkLit("wrap_899_y", int'(bus.draw_y), 900);
      jumpTo(1902, 931);
      stepRandom();
      stepRandom();
      checkLit("wrap_931_x", int'(bus.draw_x), 0);
      checkLit("wrap_931_y", int'(bus.draw_y), 0);
      stepRandom();
      checkLit("wrap_frame_start", int'(bus.frame_start), 1);

      // Reset in the middle of both sync pulses.
      jumpTo(1598, 902);
      stepRandom();
      stepRandom();
      checkLit("pre_reset_hs", int'(bus.vga_hs), 0);
      checkLit("pre_reset_vs", int'(bus.vga_vs), 1);
      checkLit("pre_reset_x", int'(bus.draw_x), 1600);
      pulseReset();
      stepRandom();
      checkLit("restart_frame_start", int'(bus.frame_start), 1);
      checkLit("restart_draw_x", int'(bus.draw_x), 1);

`ifdef VGA_FRAME_CNT_EN
      dep_fc = 16'hFFFF;
      force bus.frame_cnt = dep_fc;
      #1;
      release bus.frame_cnt;
      efc = 16'hFFFF;
      @(negedge clk);
      jumpTo(1902, 931);
      stepRandom();
      stepRandom();
      stepRandom();
      checkLit("frame_cnt_wrap", int'(bus.frame_cnt), 0);
`endif

      // Random jumps (biased toward region edges), random colours, occasional resets.
      for (int it = 0; it < 30; it++) begin
         int h;
         int v;
         if ($urandom_range(0, 1) == 1) begin
            h = $urandom_range(0, H_TOTAL - 1);
            v = $urandom_range(0, V_TOTAL - 1);
         end else begin
            case ($urandom_range(0, 3))
               0: h = 1440 - 3;
               1: h = 1520 - 3;
               2: h = 1672 - 3;
               default: h = H_TOTAL - 3;
            endcase
            case ($urandom_range(0, 3))
               0: v = 899;
               1: v = 900;
               2: v = 903;
               default: v = V_TOTAL - 1;
            endcase
         end
         jumpTo(h, v);
         for (int n = 0; n < int'($urandom_range(5, 120)); n++) stepRandom();
         if ($urandom_range(0, 4) == 0) pulseReset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 clk  input  1  pixel clock, 106.47 MHz nominal; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset; one clock; asynchronous, active-low.
REQ-003 draw_x  output  11  current horizontal count, 0..1903, from the register directly.
REQ-004 draw_y  output  10  current vertical count, 0..931, from the register directly.
REQ-005 r_in, g_in, b_in  input  4 each  colour from the pixel colour generator, valid in the same cycle as draw_x/draw_y.
REQ-006 vga_r, vga_g, vga_b  output  4 each  registered, blank-gated colour to the DAC pins.
REQ-007 vga_hs  output  1  registered horizontal sync, active-low.
REQ-008 vga_vs  output  1  registered vertical sync, active-high.
REQ-009 video_on  output  1  registered; 1 when the current output pixel is visible.
REQ-010 frame_start  output  1  registered one-cycle pulse marking the first output pixel of a frame.

Function
REQ-011 Horizontal timing is fixed: 1440 visible, 80 front porch, 152 sync, 232 back porch, 1904 total.
REQ-012 Vertical timing is fixed, in lines: 900 visible, 1 front porch, 3 sync, 28 back porch, 932 total.
REQ-013 h_cnt increments every cycle and wraps 1903->0.
REQ-014 v_cnt increments only on the h_cnt 1903->0 wrap.
REQ-015 v_cnt wraps 931->0 when both counters are at maximum, so the next cycle is (0,0).
REQ-016 draw_x = h_cnt and draw_y = v_cnt; no added latency.
REQ-017 visible = (h_cnt < 1440) and (v_cnt < 900).
REQ-018 Output latency is exactly 1 cycle; every registered output reflects the counter pair of the previous cycle.
REQ-019 vga_r/g/b <= r_in/g_in/b_in when visible, otherwise 0.
REQ-020 vga_hs <= 0 when 1520 <= h_cnt <= 1671, otherwise 1.
REQ-021 vga_vs <= 1 when 901 <= v_cnt <= 903 for every h_cnt of those lines, otherwise 0.
REQ-022 video_on <= visible.
REQ-023 frame_start <= 1 only when h_cnt = 0 and v_cnt = 0.
REQ-024 All counter compares are unsigned and performed at the declared widths; the counters never exceed their maximum values.
REQ-025 Input colour outside the visible region is ignored in every case.

Reset
REQ-026 While rst_n = 0, all outputs are held immediately, independent of clk, at these values:
- h_cnt = 0, v_cnt = 0
- vga_r/g/b = 0
- vga_hs = 1, vga_vs = 0
- video_on = 0, frame_start = 0
REQ-027 On the first clk edge after rst_n rises, frame_start = 1 and the counters advance to (1,0).
REQ-028 Reset asserted mid-frame abandons the frame with no partial sync pulse held; timing restarts from (0,0).

Configuration
REQ-029 Macro VGA_FRAME_CNT_EN, when defined, adds output port frame_cnt (16 bits).
REQ-030 With VGA_FRAME_CNT_EN defined, frame_cnt:
- resets to 0
- increments by 1 on each cycle where frame_start = 1 is being registered
- wraps 65535->0
REQ-031 With VGA_FRAME_CNT_EN undefined, neither the port nor the counter exists, and all other behaviour is identical.

Verification
REQ-032 Release reset, run 2 lines -> falling edges of vga_hs are 1904 cycles apart; hs low width is 152 cycles; first falling edge is 1521 cycles after release.
REQ-033 Run 2 frames -> vga_vs rises 1774528 cycles apart; vs high width is 5712 cycles; frame_start pulses 1774528 cycles apart.
REQ-034 Hold r_in/g_in/b_in = F/F/F -> vga_rgb = FFF for exactly 1440 cycles per visible line and 0 otherwise; 900 such lines per frame; video_on matches.
REQ-035 Observe the counter boundary (1903,899) -> next cycle draw_x = 0, draw_y = 900; at (1903,931) -> next cycle (0,0).
REQ-036 Assert rst_n low at draw_x = 1600, draw_y = 902, with no clk edge -> outputs take reset values at once; after release, timing restarts per REQ-027.
REQ-037 With VGA_FRAME_CNT_EN defined, force frame_cnt to 65535 and run 1 frame -> frame_cnt = 0; without the macro, the design elaborates with no frame_cnt port.
